inta_sequencer: RTL and testbench
=================================

# inta_sequencer

Interrupt-acknowledge controller for the 8259A PIC. It raises INT toward the CPU when the priority resolver reports a pending request. It then tracks the CPU's INTA pulses and issues the one-cycle strobes that make the in-service register latch the winning level and emit its vector. It supports 8086 mode (two INTA pulses) and 8080 mode (three INTA pulses: CALL opcode, low address byte, high address byte). It sits between the control logic and the in-service register, and drives the data-buffer enable for every acknowledge byte.

## Interface
- `VEC_W`, default 8: data-bus / vector width.
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `initDone`  in  1  ICW sequence complete; while low the block is held in IDLE.
- `intReq`  in  1  priority resolver has an unmasked request of higher priority than any in service.
- `highestIndex`  in  3  index of the winning IR level.
- `INTA_n`  in  1  CPU acknowledge, active low, already synchronised to `clk`.
- `mode8086`  in  1  ICW4 bit 0: 1 = 8086 mode, 0 = 8080 mode.
- `aeoi`  in  1  ICW4 bit 1: automatic end-of-interrupt.
- `ICW2`  in  8  vector base (8086 mode) or high address byte (8080 mode).
- `addrLow`  in  3  ICW1[7:5], used for the 8080 low address byte; interval is fixed at 4.
- `INT`  out  1  interrupt request to the CPU.
- `readPriority`  out  1  one-cycle strobe: freeze and sample the resolver.
- `setIsr`  out  1  one-cycle strobe: set ISR bit `toSet`.
- `toSet`  out  3  latched serviced index.
- `sendVector`  out  1  one-cycle strobe to the ISR: present vector.
- `secondACK`  out  1  one-cycle strobe at the end of the final INTA.
- `aeoiPulse`  out  1  one-cycle strobe: clear ISR bit `toSet` (AEOI).
- `dataOut`  out  8  byte for the current acknowledge cycle.
- `dataEnable`  out  1  drive the data bus.
- `busy`  out  1  sequence in progress (any state other than IDLE).

## Operation
- States:
  - IDLE: go to REQ when `initDone & intReq`.
  - REQ: `INT`=1; on an INTA fall go to ACK1.
  - ACK1: on an INTA rise go to WAIT2.
  - WAIT2: on an INTA fall go to ACK2.
  - ACK2: on an INTA rise, if `mode8086` go to IDLE; otherwise go to WAIT3.
  - WAIT3: on an INTA fall go to ACK3.
  - ACK3: on an INTA rise go to IDLE.
- Edge detection: fall = `intaQ & ~INTA_n`; rise = `~intaQ & INTA_n`. `intaQ` is a register of `INTA_n` that resets to 1.
- Fall entering ACK1:
  - Pulse `readPriority`.
  - Latch `toSet` = `highestIndex`.
  - Pulse `setIsr` only if `intReq` is still 1.
  - Drop `INT`.
- Spurious acknowledge: if `intReq`=0 at that fall, set `toSet`=7 and do not pulse `setIsr`. The vector is still delivered.
- Data bytes:
  - 8086 mode: ACK1 drives no data. ACK2 drives `{ICW2[7:3], toSet}`, and `sendVector` pulses on entry to ACK2.
  - 8080 mode: ACK1 drives 8'hCD. ACK2 drives `{addrLow, toSet, 2'b00}`, with `sendVector` pulsed on entry. ACK3 drives `ICW2`.
- `dataEnable`=1 only while in a data-driving ACK state.
- Final rise (ACK2 in 8086 mode, ACK3 in 8080 mode): pulse `secondACK`. If `aeoi`=1, pulse `aeoiPulse` in the same cycle.
- INTA edges seen in IDLE are ignored.
- `initDone` low forces IDLE from any state: strobes 0, `dataEnable` 0.
- A new `intReq` during a sequence is ignored. It is re-evaluated in IDLE after completion.

## Timing
- Reset values: state IDLE, `INT`=0, all strobes 0, `toSet`=0, `dataOut`=0, `dataEnable`=0, `busy`=0, `intaQ`=1.
- Reset asserted mid-sequence aborts the sequence immediately, asynchronously.
- IDLE→REQ takes 1 cycle. `INT` is high in the cycle after `intReq` is sampled.
- Edge response: an edge sampled at clock edge k produces the registered outputs (strobes, `dataOut`, `dataEnable`, state) after edge k.
- Every strobe is exactly 1 cycle wide.
- `dataEnable` falls in the cycle after the rise is sampled.
- If an INTA low is shorter than 1 cycle (fall and rise within the same sample), the edges are not observed; this is not supported.
- Minimum sequence length: 8086 mode 4 edges; 8080 mode 6 edges.

## Test plan
- Normal 8086 acknowledge: mode8086=1, ICW2=8'h40, highestIndex=5, intReq=1, two INTA pulses of 4 cycles each.
  - Required: INT=1, then 0 after the first fall.
  - setIsr with toSet=5.
  - dataOut=8'h45 with dataEnable during the second pulse.
  - secondACK at the second rise; no aeoiPulse.
- AEOI: same stimulus with aeoi=1. Required: aeoiPulse coincides with secondACK; state returns to IDLE.
- 8080 mode: addrLow=3'b101, ICW2=8'h12, highestIndex=2, three INTA pulses. Required data bytes are CD, A8, 12, in that order.
- Spurious acknowledge: intReq drops before the first fall. Required: toSet=7, no setIsr, vector `{ICW2[7:3],3'b111}` still sent.
- Abort cases:
  - reset asserted in WAIT2: all outputs at reset values immediately.
  - initDone dropped in ACK2: IDLE next cycle with dataEnable=0.
- Stray INTA: INTA pulse while in IDLE. Required: no strobes, dataEnable stays 0.

Source files
------------

// File: rtl/inta_sequencer.sv
// 8259A interrupt-acknowledge sequencer: raises INT, follows the CPU's INTA pulses, strobes the ISR and drives vector bytes.
// Outputs are registered one clock after the sampled INTA edge; the CPU paces the sequence and there is no backpressure.
module inta_sequencer #(
   parameter int VEC_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             initDone,
   input  logic             intReq,
   input  logic [2:0]       highestIndex,
   input  logic             INTA_n,
   input  logic             mode8086,
   input  logic             aeoi,
   input  logic [VEC_W-1:0] ICW2,
   input  logic [2:0]       addrLow,
   output logic             INT,
   output logic             readPriority,
   output logic             setIsr,
   output logic [2:0]       toSet,
   output logic             sendVector,
   output logic             secondACK,
   output logic             aeoiPulse,
   output logic [VEC_W-1:0] dataOut,
   output logic             dataEnable,
   output logic             busy
);

   typedef enum logic [2:0] {
      S_IDLE, S_REQ, S_ACK1, S_WAIT2, S_ACK2, S_WAIT3, S_ACK3
   } state_t;

   state_t state_q, state_d;
   logic inta_q;
   logic fall, rise;
   logic int_q, int_d;
   logic read_priority_q, read_priority_d;
   logic set_isr_q, set_isr_d;
   logic send_vector_q, send_vector_d;
   logic second_ack_q, second_ack_d;
   logic aeoi_pulse_q, aeoi_pulse_d;
   logic data_enable_q, data_enable_d;
   logic busy_q, busy_d;
   logic [2:0] to_set_q, to_set_d;
   logic [VEC_W-1:0] data_out_q, data_out_d;

   assign fall = inta_q & ~INTA_n;
   assign rise = ~inta_q & INTA_n;

   always_comb begin
      state_d         = state_q;
      to_set_d        = to_set_q;
      read_priority_d = 1'b0;
      set_isr_d       = 1'b0;
      send_vector_d   = 1'b0;
      second_ack_d    = 1'b0;
      aeoi_pulse_d    = 1'b0;
      case (state_q)
         S_IDLE:  if (intReq) state_d = S_REQ;
         S_REQ:
            if (fall) begin
               // A request that vanished before the acknowledge is spurious: service level 7
               state_d         = S_ACK1;
               read_priority_d = 1'b1;
               set_isr_d       = intReq;
               to_set_d        = intReq ? highestIndex : 3'd7;
            end
         S_ACK1:  if (rise) state_d = S_WAIT2;
         S_WAIT2:
            if (fall) begin
               state_d       = S_ACK2;
               send_vector_d = 1'b1;
            end
         S_ACK2:
            if (rise) begin
               if (mode8086) begin
                  state_d      = S_IDLE;
                  second_ack_d = 1'b1;
                  aeoi_pulse_d = aeoi;
               end else begin
                  state_d = S_WAIT3;
               end
            end
         S_WAIT3: if (fall) state_d = S_ACK3;
         S_ACK3:
            if (rise) begin
               state_d      = S_IDLE;
               second_ack_d = 1'b1;
               aeoi_pulse_d = aeoi;
            end
         default: state_d = S_IDLE;
      endcase

      if (!initDone) begin
         state_d         = S_IDLE;
         read_priority_d = 1'b0;
         set_isr_d       = 1'b0;
         send_vector_d   = 1'b0;
         second_ack_d    = 1'b0;
         aeoi_pulse_d    = 1'b0;
      end

      int_d         = (state_d == S_REQ);
      busy_d        = (state_d != S_IDLE);
      data_enable_d = 1'b0;
      data_out_d    = '0;
      case (state_d)
         S_ACK1:
            if (!mode8086) begin
               data_enable_d = 1'b1;
               data_out_d    = VEC_W'(8'hCD);
            end
         S_ACK2: begin
            data_enable_d = 1'b1;
            data_out_d    = mode8086 ? {ICW2[VEC_W-1:3], to_set_d}
                                     : VEC_W'({addrLow, to_set_d, 2'b00});
         end
         S_ACK3: begin
            data_enable_d = 1'b1;
            data_out_d    = ICW2;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q         <= S_IDLE;
         inta_q          <= 1'b1;
         int_q           <= 1'b0;
         read_priority_q <= 1'b0;
         set_isr_q       <= 1'b0;
         send_vector_q   <= 1'b0;
         second_ack_q    <= 1'b0;
         aeoi_pulse_q    <= 1'b0;
         data_enable_q   <= 1'b0;
         busy_q          <= 1'b0;
         to_set_q        <= 3'd0;
         data_out_q      <= '0;
      end else begin
         state_q         <= state_d;
         inta_q          <= INTA_n;
         int_q           <= int_d;
         read_priority_q <= read_priority_d;
         set_isr_q       <= set_isr_d;
         send_vector_q   <= send_vector_d;
         second_ack_q    <= second_ack_d;
         aeoi_pulse_q    <= aeoi_pulse_d;
         data_enable_q   <= data_enable_d;
         busy_q          <= busy_d;
         to_set_q        <= to_set_d;
         data_out_q      <= data_out_d;
      end
   end

   assign INT          = int_q;
   assign readPriority = read_priority_q;
   assign setIsr       = set_isr_q;
   assign toSet        = to_set_q;
   assign sendVector   = send_vector_q;
   assign secondACK    = second_ack_q;
   assign aeoiPulse    = aeoi_pulse_q;
   assign dataOut      = data_out_q;
   assign dataEnable   = data_enable_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_inta_sequencer.sv
// Transaction-level bench for inta_sequencer: each acknowledge sequence is predicted per INTA pulse
// from the byte/strobe rules of the 8259A and compared a cycle at a time.
module tb_inta_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       initDone;
   logic       intReq;
   logic [2:0] highestIndex;
   logic       INTA_n;
   logic       mode8086;
   logic       aeoi;
   logic [7:0] ICW2;
   logic [2:0] addrLow;
   logic       INT;
   logic       readPriority;
   logic       setIsr;
   logic [2:0] toSet;
   logic       sendVector;
   logic       secondACK;
   logic       aeoiPulse;
   logic [7:0] dataOut;
   logic       dataEnable;
   logic       busy;

   int vectors = 0;
   int miscompares = 0;

   inta_sequencer #(.VEC_W(8)) dut (
      .clk(clk), .reset(reset), .initDone(initDone), .intReq(intReq),
      .highestIndex(highestIndex), .INTA_n(INTA_n), .mode8086(mode8086),
      .aeoi(aeoi), .ICW2(ICW2), .addrLow(addrLow), .INT(INT),
      .readPriority(readPriority), .setIsr(setIsr), .toSet(toSet),
      .sendVector(sendVector), .secondACK(secondACK), .aeoiPulse(aeoiPulse),
      .dataOut(dataOut), .dataEnable(dataEnable), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_strobes"}, {readPriority, setIsr, sendVector, secondACK, aeoiPulse}, 5'b0);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_int"}, INT, 1'b0);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_de"}, dataEnable, 1'b0);
      check({tag, "_dout"}, dataOut, 8'h00);
      check({tag, "_toset"}, toSet, 3'd0);
      check_quiet(tag);
   endtask

   // Byte the CPU must see on acknowledge pulse p
   function automatic logic [7:0] exp_byte(input bit m86, input int p, input logic [7:0] icw2,
                                           input logic [2:0] al, input logic [2:0] ts);
      if (m86) return {icw2[7:3], ts};
      if (p == 1) return 8'hCD;
      if (p == 2) return {al, ts, 2'b00};
      return icw2;
   endfunction

   // abort: 0 none, 1 reset while waiting for the second pulse, 2 initDone dropped in the second pulse
   task automatic run_seq(input bit m86, input bit ae, input logic [7:0] icw2, input logic [2:0] al,
                          input logic [2:0] idx, input bit spur, input int plen, input int gap,
                          input int abort);
      int npulse;
      logic [2:0] ts;
      bit en, last;
      logic [7:0] b;
      mode8086 = m86; aeoi = ae; ICW2 = icw2; addrLow = al;
      highestIndex = idx; intReq = 1'b1; INTA_n = 1'b1;
      tick();
      check("int_raise", INT, 1'b1);
      check("busy_req", busy, 1'b1);
      if (spur) begin
         intReq = 1'b0;
         tick();
         check("int_hold", INT, 1'b1);
      end
      npulse = m86 ? 2 : 3;
      ts = spur ? 3'd7 : idx;
      for (int p = 1; p <= npulse; p++) begin
         INTA_n = 1'b0;
         tick();
         check("read_priority", readPriority, p == 1);
         check("set_isr", setIsr, (p == 1) && !spur);
         check("send_vector", sendVector, p == 2);
         check("second_ack_early", secondACK, 1'b0);
         if (p == 1) begin
            check("to_set", toSet, ts);
            check("int_drop", INT, 1'b0);
            highestIndex = 3'($urandom);
            intReq = 1'($urandom);
         end
         en = m86 ? (p == 2) : 1'b1;
         b  = exp_byte(m86, p, icw2, al, ts);
         check("data_en", dataEnable, en);
         if (en) check("data_out", dataOut, b);
         if (abort == 2 && p == 2) begin
            initDone = 1'b0; intReq = 1'b0;
            tick();
            check("abort_busy", busy, 1'b0);
            check("abort_de", dataEnable, 1'b0);
            check_quiet("abort_init");
            initDone = 1'b1; INTA_n = 1'b1;
            tick();
            check("abort_no_ack", secondACK, 1'b0);
            check("abort_idle", busy, 1'b0);
            return;
         end
         for (int c = 1; c < plen; c++) begin
            tick();
            check_quiet("pulse_hold");
            check("data_en_hold", dataEnable, en);
            if (en) check("data_out_hold", dataOut, b);
         end
         INTA_n = 1'b1;
         tick();
         last = (p == npulse);
         check("second_ack", secondACK, last);
         check("aeoi_pulse", aeoiPulse, last && ae);
         check("data_en_off", dataEnable, 1'b0);
         check("busy_seq", busy, !last);
         if (last) intReq = 1'b0;
         if (abort == 1 && p == 1) begin
            intReq = 1'b0;
            #2 reset = 1'b1;
            #1 check_reset_values("async_reset");
            tick();
            reset = 1'b0;
            return;
         end
         for (int c = 0; c < gap; c++) begin
            tick();
            check_quiet("gap");
            check("gap_de", dataEnable, 1'b0);
            if (last) begin
               check("idle_busy", busy, 1'b0);
               check("idle_int", INT, 1'b0);
            end
         end
      end
   endtask

   initial begin
      reset = 1'b1; initDone = 1'b0; intReq = 1'b0; highestIndex = 3'd0; INTA_n = 1'b1;
      mode8086 = 1'b1; aeoi = 1'b0; ICW2 = 8'h00; addrLow = 3'd0;
      #2 check_reset_values("reset");
      tick(); tick();
      reset = 1'b0;
      check_reset_values("post_reset");

      intReq = 1'b1;
      tick(); tick();
      check("no_init_int", INT, 1'b0);
      check("no_init_busy", busy, 1'b0);
      intReq = 1'b0; initDone = 1'b1;
      tick();

      run_seq(1'b1, 1'b0, 8'h40, 3'd0, 3'd5, 1'b0, 4, 2, 0);
      run_seq(1'b1, 1'b1, 8'h40, 3'd0, 3'd5, 1'b0, 4, 2, 0);
      run_seq(1'b0, 1'b0, 8'h12, 3'b101, 3'd2, 1'b0, 4, 2, 0);
      run_seq(1'b1, 1'b0, 8'h40, 3'd0, 3'd5, 1'b1, 3, 2, 0);
      run_seq(1'b1, 1'b0, 8'h88, 3'd0, 3'd3, 1'b0, 3, 2, 1);
      run_seq(1'b1, 1'b0, 8'h88, 3'd0, 3'd3, 1'b0, 3, 2, 2);

      // Stray acknowledge while idle
      INTA_n = 1'b0;
      tick();
      check_quiet("stray_fall");
      check("stray_de", dataEnable, 1'b0);
      check("stray_busy", busy, 1'b0);
      tick();
      INTA_n = 1'b1;
      tick();
      check_quiet("stray_rise");
      check("stray_de2", dataEnable, 1'b0);

      for (int i = 0; i < 40; i++) begin
         run_seq(1'($urandom), 1'($urandom), 8'($urandom), 3'($urandom), 3'($urandom),
                 ($urandom_range(3) == 0), $urandom_range(1, 4), $urandom_range(1, 3), 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
